// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: a trigger starts a level pulse of 'len' cycles followed by a holdoff gap.
// Define PULSE_STRETCH_RETRIG_EN to let a trigger during an active pulse reload the length.
module pulse_stretch #(
  parameter int LEN_W   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [LEN_W-1:0] len,
  output logic             level,
  output logic             busy,
  output logic             done,
  output logic             drop
);

  // state  | meaning
  // IDLE   | waiting for a trigger with non-zero length
  // ACTIVE | level high, cnt counts remaining high cycles
  // HOLD   | forced low gap of HOLDOFF cycles, triggers dropped
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

`ifdef PULSE_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam logic [3:0]       HOLD_INIT = 4'(HOLDOFF);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [3:0]       hold_cnt, hold_cnt_nxt;
  logic             done_nxt, drop_nxt;
  logic             len_ok;

  assign len_ok = (len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      level    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      level    <= (state_nxt == ACTIVE);
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
      drop     <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_cnt_nxt = hold_cnt;
    done_nxt     = 1'b0;
    drop_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          if (len_ok) begin
            state_nxt = ACTIVE;
            cnt_nxt   = len;
          end else begin
            drop_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (RETRIG && trig && len_ok) begin
          cnt_nxt = len;
        end else begin
          drop_nxt = trig;
          // <= keeps the counter from ever wrapping below 1
          if (cnt <= ONE) begin
            done_nxt = 1'b1;
            cnt_nxt  = '0;
            if (HOLDOFF > 0) begin
              state_nxt    = HOLD;
              hold_cnt_nxt = HOLD_INIT;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      HOLD: begin
        drop_nxt = trig;
        if (hold_cnt <= 4'd1) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the length input and internal counter.
REQ-002 SHALL have parameter HOLDOFF, default 2: idle cycles forced after each output pulse; range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port trig, input, 1: trigger; sampled every rising clk edge; each cycle it is high counts as one trigger.
REQ-006 SHALL have port len, input, LEN_W: output pulse length in cycles; sampled only on an accepted trigger.
REQ-007 SHALL have port level, output, 1: stretched output pulse; registered.
REQ-008 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle strobe marking completion of a level pulse.
REQ-010 SHALL have port drop, output, 1: one-cycle strobe, asserted the cycle after an ignored trigger.

Function
REQ-011 SHALL implement three states: IDLE, ACTIVE, HOLD.
REQ-012 In IDLE, trig=1 with len!=0 SHALL load the counter with len and enter ACTIVE at the next edge; level rises 1 cycle after the trigger cycle.
REQ-013 In IDLE, trig=1 with len=0 SHALL be ignored: state stays IDLE and drop pulses.
REQ-014 In ACTIVE, level SHALL be 1 and the counter SHALL decrement by 1 per cycle; level stays high for exactly len cycles (1..2^LEN_W-1).
REQ-015 On the ACTIVE cycle with counter==1 and no accepted retrigger, the next state SHALL be HOLD if HOLDOFF>0, else IDLE.
REQ-016 done SHALL pulse high for exactly one cycle: the first cycle after the last level-high cycle.
REQ-017 HOLD SHALL last exactly HOLDOFF cycles with level=0, then return to IDLE; every trig during HOLD is ignored and causes drop.
REQ-018 In ACTIVE, trig handling SHALL depend on REQ-025/REQ-026.
REQ-019 A trig held high across IDLE SHALL start a new pulse on the first IDLE cycle after HOLD.
REQ-020 Counter arithmetic SHALL be unsigned LEN_W bits and SHALL never wrap below 1 while in ACTIVE.

Reset
REQ-021 While rst_n=0, level, busy, done and drop SHALL be 0 immediately, without waiting for a clk edge.
REQ-022 While rst_n=0, state SHALL be IDLE and the counter SHALL be 0.
REQ-023 Reset asserted mid-ACTIVE or mid-HOLD SHALL abort the operation with no done strobe.
REQ-024 The first trig SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-025 With PULSE_STRETCH_RETRIG_EN defined, trig=1 with len!=0 in ACTIVE SHALL reload the counter with len; level stays high continuously, no done is issued, and no drop is issued. A retrigger on the final ACTIVE cycle also reloads. trig with len=0 in ACTIVE is ignored and causes drop.
REQ-026 Without PULSE_STRETCH_RETRIG_EN, every trig in ACTIVE SHALL be ignored and SHALL cause drop; the pulse length is unchanged.

Verification (HOLDOFF=2, trigger on cycle 0)
REQ-027 Basic pulse: len=3, one-cycle trig -> level=1 on cycles 1-3; done on cycle 4; busy on cycles 1-5; IDLE on cycle 6.
REQ-028 Zero length: len=0, trig -> drop on cycle 1; level and busy stay 0.
REQ-029 Retrigger: len=4, trig on cycles 0 and 2.
- With the macro defined -> level high on cycles 1-6, done on cycle 7, no drop.
- Without the macro -> level high on cycles 1-4, drop on cycle 3, done on cycle 5.
REQ-030 Holdoff rejection: len=1, trig on cycles 0 and 3 -> level on cycle 1 only, done on cycle 2, drop on cycle 4; a trig on cycle 4 produces level on cycle 5.
REQ-031 Reset abort: len=10, trig, then rst_n=0 mid-cycle 4 -> level drops immediately, no done; after release, a new trig behaves as in REQ-027.
REQ-032 Maximum length: len=255, single trig -> level high for exactly 255 cycles, done on cycle 256.
